// File: rtl/pipelined_control.sv
// Pipelined main control for a 5-stage RV32I core: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall detection, flush bubbles and EX-stage forwarding selects.
module pipelined_control #(
  parameter int unsigned TAM_INS      = 7,
  parameter int unsigned TAM_ALUOP    = 2,
  parameter int unsigned TAM_AUIPCLUI = 2,
  parameter int unsigned TAM_REG      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instruction,
  input  logic                    flush,
  output logic                    stall,
  output logic                    ex_alusrc,
  output logic [TAM_ALUOP-1:0]    ex_aluop,
  output logic [TAM_AUIPCLUI-1:0] ex_auipclui,
  output logic                    ex_branch,
  output logic [1:0]              ex_jump,
  output logic                    ex_illegal,
  output logic [1:0]              fwd_a,
  output logic [1:0]              fwd_b,
  output logic                    mem_memread,
  output logic                    mem_memwrite,
  output logic                    wb_memtoreg,
  output logic                    wb_link,
  output logic                    wb_regwrite,
  output logic [TAM_REG-1:0]      wb_rd
);

  localparam logic [TAM_INS-1:0] OpR     = TAM_INS'(7'b0110011);
  localparam logic [TAM_INS-1:0] OpI     = TAM_INS'(7'b0010011);
  localparam logic [TAM_INS-1:0] OpLoad  = TAM_INS'(7'b0000011);
  localparam logic [TAM_INS-1:0] OpStore = TAM_INS'(7'b0100011);
  localparam logic [TAM_INS-1:0] OpBr    = TAM_INS'(7'b1100011);
  localparam logic [TAM_INS-1:0] OpLui   = TAM_INS'(7'b0110111);
  localparam logic [TAM_INS-1:0] OpAuipc = TAM_INS'(7'b0010111);
  localparam logic [TAM_INS-1:0] OpJal   = TAM_INS'(7'b1101111);
  localparam logic [TAM_INS-1:0] OpJalr  = TAM_INS'(7'b1100111);

  typedef struct packed {
    logic                    alusrc;
    logic [TAM_ALUOP-1:0]    aluop;
    logic [TAM_AUIPCLUI-1:0] auipclui;
    logic                    branch;
    logic [1:0]              jump;
    logic                    illegal;
    logic                    memread;
    logic                    memwrite;
    logic                    memtoreg;
    logic                    link;
    logic                    regwrite;
    logic [TAM_REG-1:0]      rd;
    logic [TAM_REG-1:0]      rs1;
    logic [TAM_REG-1:0]      rs2;
  } idex_t;

  typedef struct packed {
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               link;
    logic               regwrite;
    logic [TAM_REG-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic               memtoreg;
    logic               link;
    logic               regwrite;
    logic [TAM_REG-1:0] rd;
  } memwb_t;

  logic [TAM_INS-1:0] opcode;
  logic [TAM_REG-1:0] id_rd, id_rs1, id_rs2;
  logic               uses_rs1, uses_rs2;
  logic               load_use;
  idex_t              dec, idex_d, idex_q;
  exmem_t             exmem_d, exmem_q;
  memwb_t             memwb_d, memwb_q;
  logic               unused_fields;

  assign opcode = instruction[TAM_INS-1:0];
  assign id_rd  = instruction[7 +: TAM_REG];
  assign id_rs1 = instruction[15 +: TAM_REG];
  assign id_rs2 = instruction[20 +: TAM_REG];
  assign unused_fields = ^{instruction[31:25], instruction[14:12]};

  // ID decode
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OpR: begin
        dec.regwrite = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OpI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = TAM_ALUOP'(2'b01);
        uses_rs1     = 1'b1;
      end
      OpLoad: begin
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = TAM_ALUOP'(2'b01);
        uses_rs1     = 1'b1;
      end
      OpStore: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = TAM_ALUOP'(2'b10);
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
      end
      OpBr: begin
        dec.branch = 1'b1;
        dec.alusrc = 1'b1;
        dec.aluop  = TAM_ALUOP'(2'b11);
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OpLui: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = TAM_ALUOP'(2'b01);
        dec.auipclui = TAM_AUIPCLUI'(2'b01);
      end
      OpAuipc: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = TAM_ALUOP'(2'b01);
        dec.auipclui = TAM_AUIPCLUI'(2'b10);
      end
      OpJal: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = TAM_ALUOP'(2'b01);
        dec.jump     = 2'b01;
        dec.link     = 1'b1;
      end
      OpJalr: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = TAM_ALUOP'(2'b01);
        dec.jump     = 2'b10;
        dec.link     = 1'b1;
        uses_rs1     = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // rd only carries meaning when the instruction writes the register file
    dec.rd  = dec.regwrite ? id_rd : '0;
    dec.rs1 = id_rs1;
    dec.rs2 = id_rs2;
  end

  assign load_use = idex_q.memread && (idex_q.rd != '0) &&
                    ((uses_rs1 && (id_rs1 == idex_q.rd)) || (uses_rs2 && (id_rs2 == idex_q.rd)));

  // A taken branch/jump squashes the younger instruction, so there is nothing to stall for
  assign stall = load_use && !flush;

  always_comb begin
    idex_d = (flush || load_use) ? '0 : dec;

    exmem_d.memread  = idex_q.memread;
    exmem_d.memwrite = idex_q.memwrite;
    exmem_d.memtoreg = idex_q.memtoreg;
    exmem_d.link     = idex_q.link;
    exmem_d.regwrite = idex_q.regwrite;
    exmem_d.rd       = idex_q.rd;

    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.link     = exmem_q.link;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.rd       = exmem_q.rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // EX/MEM result is younger than MEM/WB, so it wins
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs1)) begin
      fwd_a = 2'b10;
    end else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs1)) begin
      fwd_a = 2'b01;
    end
    if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs2)) begin
      fwd_b = 2'b10;
    end else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs2)) begin
      fwd_b = 2'b01;
    end
  end

  assign ex_alusrc    = idex_q.alusrc;
  assign ex_aluop     = idex_q.aluop;
  assign ex_auipclui  = idex_q.auipclui;
  assign ex_branch    = idex_q.branch;
  assign ex_jump      = idex_q.jump;
  assign ex_illegal   = idex_q.illegal;
  assign mem_memread  = exmem_q.memread;
  assign mem_memwrite = exmem_q.memwrite;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_link      = memwb_q.link;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_rd        = memwb_q.rd;

endmodule

// File: tb/tb_pipelined_control.sv
// Bench for pipelined_control: decode table vectors, hand-written hazard/flush/reset sequences
// and random instruction streams checked against a slot-queue model of the pipeline.
module tb_pipelined_control;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ILL   = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = '0;
  logic        flush = 1'b0;
  logic        stall, ex_alusrc, ex_branch, ex_illegal;
  logic [1:0]  ex_aluop, ex_auipclui, ex_jump, fwd_a, fwd_b;
  logic        mem_memread, mem_memwrite, wb_memtoreg, wb_link, wb_regwrite;
  logic [4:0]  wb_rd;
  logic [8:0]  exbits;
  logic [18:0] dut_regs;

  pipelined_control dut (
    .clk(clk), .rst(rst), .instruction(instruction), .flush(flush), .stall(stall),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_auipclui(ex_auipclui),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_memtoreg(wb_memtoreg), .wb_link(wb_link), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  assign exbits   = {ex_alusrc, ex_aluop, ex_auipclui, ex_branch, ex_jump, ex_illegal};
  assign dut_regs = {exbits, mem_memread, mem_memwrite, wb_memtoreg, wb_link, wb_regwrite, wb_rd};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [6:0] op;
    logic s, w, mr, mt, mw, b;
    logic [1:0] aluop, ai, j;
    logic u1, u2;
  } dec_t;

  typedef struct packed {
    logic s; logic [1:0] aluop; logic [1:0] ai; logic b; logic [1:0] j; logic ill;
    logic mr, mw, mt, lk, w;
    logic [4:0] rd, rs1, rs2;
    logic u1, u2;
  } slot_t;

  dec_t  dtab [9];
  slot_t pipe [3];  // 0: ID/EX, 1: EX/MEM, 2: MEM/WB

  function automatic dec_t mkdec(input logic [6:0] op, input logic s, w, mr, mt, mw, b,
                                 input logic [1:0] aluop, ai, j, input logic u1, u2);
    dec_t d;
    d.op = op; d.s = s; d.w = w; d.mr = mr; d.mt = mt; d.mw = mw; d.b = b;
    d.aluop = aluop; d.ai = ai; d.j = j; d.u1 = u1; d.u2 = u2;
    return d;
  endfunction

  task automatic init_tab();
    //                 op        S  W  MR MT MW B  aluop  ai     j      u1 u2
    dtab[0] = mkdec(OP_R,     0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1);
    dtab[1] = mkdec(OP_I,     1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    dtab[2] = mkdec(OP_LOAD,  1, 1, 1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    dtab[3] = mkdec(OP_S,     1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 1, 1);
    dtab[4] = mkdec(OP_B,     1, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 1, 1);
    dtab[5] = mkdec(OP_LUI,   1, 1, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    dtab[6] = mkdec(OP_AUIPC, 1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0);
    dtab[7] = mkdec(OP_JAL,   1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0, 0);
    dtab[8] = mkdec(OP_JALR,  1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 1, 0);
  endtask

  function automatic slot_t decode(input logic [31:0] ins);
    slot_t r = '0;
    r.ill = 1'b1;
    foreach (dtab[k]) begin
      if (dtab[k].op == ins[6:0]) begin
        r.ill = 1'b0; r.s = dtab[k].s; r.w = dtab[k].w; r.mr = dtab[k].mr;
        r.mt = dtab[k].mt; r.mw = dtab[k].mw; r.b = dtab[k].b; r.aluop = dtab[k].aluop;
        r.ai = dtab[k].ai; r.j = dtab[k].j; r.u1 = dtab[k].u1; r.u2 = dtab[k].u2;
      end
    end
    r.lk  = (r.j != 2'b00);
    r.rd  = r.w ? ins[11:7] : 5'd0;
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    return r;
  endfunction

  function automatic logic m_stall(input logic [31:0] ins, input logic fl);
    slot_t d = decode(ins);
    return !fl && pipe[0].mr && (pipe[0].rd != 0) &&
           ((d.u1 && d.rs1 == pipe[0].rd) || (d.u2 && d.rs2 == pipe[0].rd));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (pipe[1].w && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].w && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [18:0] m_regs();
    return {pipe[0].s, pipe[0].aluop, pipe[0].ai, pipe[0].b, pipe[0].j, pipe[0].ill,
            pipe[1].mr, pipe[1].mw, pipe[2].mt, pipe[2].lk, pipe[2].w, pipe[2].rd};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
  endtask

  // ---------------- stimulus helpers (all called in the low clock phase) ----------------
  task automatic drive(input logic [31:0] ins, input logic fl);
    instruction = ins;
    flush = fl;
    #1;
    check("model_comb", {stall, fwd_a, fwd_b},
          {m_stall(ins, fl), m_fwd(pipe[0].rs1), m_fwd(pipe[0].rs2)});
    check("model_regs", dut_regs, m_regs());
  endtask

  task automatic clk_adv();
    slot_t nw;
    @(posedge clk);
    if (!rst) begin
      nw = (flush || m_stall(instruction, flush)) ? slot_t'('0) : decode(instruction);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_clear();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  typedef struct {
    logic [6:0] op;
    logic [8:0] ex;
    logic [1:0] mem;
    logic [2:0] wb;   // memtoreg, link, regwrite
    logic [4:0] rd;
  } vec_t;

  vec_t          vt [10];
  logic [31:0]   nop, lw5, add6, ins;
  logic [6:0]    ops [11];

  initial begin
    init_tab();
    model_clear();
    nop  = mk(OP_I, 5'd0, 5'd0, 5'd0);
    lw5  = mk(OP_LOAD, 5'd5, 5'd1, 5'd0);
    add6 = mk(OP_R, 5'd6, 5'd5, 5'd2);

    // power-on reset, before any clock edge
    #1 rst = 1'b1;
    #1;
    check("por_regs", dut_regs, 0);
    check("por_comb", {stall, fwd_a, fwd_b}, 0);
    @(negedge clk);
    rst = 1'b0;

    // decode table: each opcode walked down the pipe behind flush bubbles
    vt[0] = '{OP_R,     9'b0_00_00_0_00_0, 2'b00, 3'b001, 5'd1};
    vt[1] = '{OP_I,     9'b1_01_00_0_00_0, 2'b00, 3'b001, 5'd1};
    vt[2] = '{OP_LOAD,  9'b1_01_00_0_00_0, 2'b10, 3'b101, 5'd1};
    vt[3] = '{OP_S,     9'b1_10_00_0_00_0, 2'b01, 3'b000, 5'd0};
    vt[4] = '{OP_B,     9'b1_11_00_1_00_0, 2'b00, 3'b000, 5'd0};
    vt[5] = '{OP_LUI,   9'b1_01_01_0_00_0, 2'b00, 3'b001, 5'd1};
    vt[6] = '{OP_AUIPC, 9'b1_01_10_0_00_0, 2'b00, 3'b001, 5'd1};
    vt[7] = '{OP_JAL,   9'b1_01_00_0_01_0, 2'b00, 3'b011, 5'd1};
    vt[8] = '{OP_JALR,  9'b1_01_00_0_10_0, 2'b00, 3'b011, 5'd1};
    vt[9] = '{OP_ILL,   9'b0_00_00_0_00_1, 2'b00, 3'b000, 5'd0};
    for (int v = 0; v < 10; v++) begin
      reset_pulse();
      drive(mk(vt[v].op, 5'd1, 5'd0, 5'd0), 1'b0);
      clk_adv();
      drive(32'd0, 1'b1);
      check($sformatf("vec%0d_ex", v), exbits, vt[v].ex);
      clk_adv();
      drive(32'd0, 1'b1);
      check($sformatf("vec%0d_mem", v), {mem_memread, mem_memwrite}, vt[v].mem);
      clk_adv();
      drive(32'd0, 1'b1);
      check($sformatf("vec%0d_wb", v), {wb_memtoreg, wb_link, wb_regwrite, wb_rd},
            {vt[v].wb, vt[v].rd});
      clk_adv();
    end

    // asynchronous reset mid-stream, then restart latency
    reset_pulse();
    drive(mk(OP_I, 5'd7, 5'd0, 5'd0), 1'b0);
    clk_adv();
    drive(lw5, 1'b0);
    clk_adv();
    drive(add6, 1'b0);
    rst = 1'b1;
    #1;
    model_clear();
    check("async_rst_regs", dut_regs, 0);
    check("async_rst_comb", {stall, fwd_a, fwd_b}, 0);
    clk_adv();
    check("rst_held_regs", dut_regs, 0);
    rst = 1'b0;
    drive(mk(OP_I, 5'd9, 5'd0, 5'd0), 1'b0);
    for (int c = 1; c <= 3; c++) begin
      clk_adv();
      drive(32'd0, 1'b1);
      check($sformatf("restart_wb_regwrite_c%0d", c), wb_regwrite, (c == 3) ? 1 : 0);
    end
    check("restart_wb_rd", wb_rd, 9);
    clk_adv();

    // load-use: one stall with a bubble, then forward from MEM/WB
    reset_pulse();
    drive(lw5, 1'b0);
    clk_adv();
    drive(add6, 1'b0);
    check("lu_stall", stall, 1);
    clk_adv();
    drive(add6, 1'b0);
    check("lu_stall_once", stall, 0);
    check("lu_bubble_ex", exbits, 0);
    clk_adv();
    drive(nop, 1'b0);
    check("lu_fwd_a", fwd_a, 2'b01);
    check("lu_wb_memtoreg", wb_memtoreg, 1);
    check("lu_wb_rd", wb_rd, 5);
    clk_adv();

    // EX/MEM forwarding, then MEM/WB forwarding two slots later
    reset_pulse();
    drive(mk(OP_I, 5'd3, 5'd0, 5'd0), 1'b0);
    clk_adv();
    drive(mk(OP_R, 5'd4, 5'd3, 5'd3), 1'b0);
    clk_adv();
    drive(nop, 1'b0);
    check("fwd_exmem", {fwd_a, fwd_b}, 4'b1010);
    clk_adv();
    reset_pulse();
    drive(mk(OP_I, 5'd3, 5'd0, 5'd0), 1'b0);
    clk_adv();
    drive(nop, 1'b0);
    clk_adv();
    drive(mk(OP_R, 5'd4, 5'd3, 5'd3), 1'b0);
    clk_adv();
    drive(nop, 1'b0);
    check("fwd_memwb", {fwd_a, fwd_b}, 4'b0101);
    clk_adv();

    // flush: beq in EX squashes the lw in ID
    reset_pulse();
    drive(mk(OP_B, 5'd0, 5'd1, 5'd2), 1'b0);
    clk_adv();
    drive(lw5, 1'b1);
    check("flush_beq_in_ex", ex_branch, 1);
    check("flush_stall_beq", stall, 0);
    clk_adv();
    drive(nop, 1'b0);
    check("flush_ex_zero", exbits, 0);
    clk_adv();
    // flush overrides a matching load-use
    reset_pulse();
    drive(lw5, 1'b0);
    clk_adv();
    drive(add6, 1'b1);
    check("flush_masks_stall", stall, 0);
    clk_adv();
    drive(nop, 1'b0);
    check("flush_lu_ex_zero", exbits, 0);
    clk_adv();

    // x0 is never a hazard source
    reset_pulse();
    drive(mk(OP_LOAD, 5'd0, 5'd1, 5'd0), 1'b0);
    clk_adv();
    drive(mk(OP_R, 5'd6, 5'd0, 5'd0), 1'b0);
    check("x0_no_stall", stall, 0);
    clk_adv();
    drive(nop, 1'b0);
    check("x0_no_fwd", {fwd_a, fwd_b}, 0);
    clk_adv();

    // random streams on a small register set to provoke hazards
    ops = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ILL, 7'd0};
    reset_pulse();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      if (ins[6:0] == 7'd0) ins[6:0] = 7'($urandom);
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive(ins, ($urandom_range(0, 7) == 0));
      clk_adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
